// File: rtl/wb_daq_sample_writer_pkg.sv
// Shared constants for the DAQ sample writer: FSM encoding and Wishbone
// cycle-type/burst-type codes for single classic writes.
package wb_daq_sample_writer_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WAIT_DATA = 3'd1;
  localparam logic [2:0] ST_WRITE     = 3'd2;
  localparam logic [2:0] ST_RETRY     = 3'd3;
  localparam logic [2:0] ST_DONE      = 3'd4;
  localparam logic [2:0] ST_ERROR     = 3'd5;

  localparam logic [2:0] CTI_CLASSIC  = 3'b000;
  localparam logic [1:0] BTE_LINEAR   = 2'b00;
  localparam logic [3:0] SEL_WORD     = 4'hF;

endpackage

// File: rtl/wb_daq_sample_writer.sv
// Moves an upstream sample stream into RAM as single classic Wishbone writes,
// one buffered sample at a time, with retry, error and abort handling.
module wb_daq_sample_writer
  import wb_daq_sample_writer_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic          wb_clk,
  input  logic          wb_rst,
  input  logic          enable,
  input  logic [AW-1:0] start_addr,
  input  logic [CW-1:0] sample_count,
  input  logic          sample_valid,
  input  logic [DW-1:0] sample_data,
  output logic          sample_ready,
  output logic [AW-1:0] wb_master_adr_o,
  output logic [DW-1:0] wb_master_dat_o,
  output logic [3:0]    wb_master_sel_o,
  output logic          wb_master_we_o,
  output logic          wb_master_cyc_o,
  output logic          wb_master_stb_o,
  output logic [2:0]    wb_master_cti_o,
  output logic [1:0]    wb_master_bte_o,
  input  logic [DW-1:0] wb_master_dat_i,
  input  logic          wb_master_ack_i,
  input  logic          wb_master_err_i,
  input  logic          wb_master_rty_i,
  output logic          done,
  output logic          bus_error,
  output logic [CW-1:0] words_written
);

  logic [2:0]    state_q, state_d;
  logic          en_prev_q, en_prev_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [DW-1:0] dat_q, dat_d;
  logic [3:0]    sel_q, sel_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] words_q, words_d;
  logic          bus_error_q, bus_error_d;
  logic          have_q, have_d;
  logic          cyc_q, cyc_d;
  logic          done_q, done_d;

  logic          start_edge_s;
  logic          xfer_s;
  logic [CW-1:0] words_inc_s;
  logic          unused_s;

  assign start_edge_s = enable & ~en_prev_q;
  // One-deep buffer: ready only while waiting and nothing is held yet.
  assign sample_ready = (state_q == ST_WAIT_DATA) & ~have_q & enable;
  assign xfer_s       = sample_valid & sample_ready;
  assign words_inc_s  = words_q + CW'(1);
  assign unused_s     = ^{wb_master_dat_i, start_addr[1:0]};

  // Next-state and datapath update for the capture FSM.
  always_comb begin
    state_d     = state_q;
    en_prev_d   = enable;
    adr_d       = adr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    count_d     = count_q;
    words_d     = words_q;
    bus_error_d = bus_error_q;
    have_d      = have_q;
    done_d      = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
      have_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_edge_s) begin
            adr_d       = {start_addr[AW-1:2], 2'b00};
            count_d     = sample_count;
            words_d     = {CW{1'b0}};
            bus_error_d = 1'b0;
            have_d      = 1'b0;
            state_d     = (sample_count == {CW{1'b0}}) ? ST_DONE : ST_WAIT_DATA;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_WAIT_DATA: begin
          // The extra cycle after capture sets the 3-cycle-per-word cadence.
          if (have_q) begin
            sel_d   = SEL_WORD;
            state_d = ST_WRITE;
          end else if (xfer_s) begin
            dat_d  = sample_data;
            have_d = 1'b1;
          end else begin
            state_d = ST_WAIT_DATA;
          end
        end
        ST_WRITE: begin
          if (wb_master_err_i) begin
            bus_error_d = 1'b1;
            have_d      = 1'b0;
            state_d     = ST_ERROR;
          end else if (wb_master_ack_i) begin
            words_d = words_inc_s;
            adr_d   = adr_q + AW'(4);
            have_d  = 1'b0;
            state_d = (words_inc_s == count_q) ? ST_DONE : ST_WAIT_DATA;
          end else if (wb_master_rty_i) begin
            state_d = ST_RETRY;
          end else begin
            state_d = ST_WRITE;
          end
        end
        ST_RETRY: state_d = ST_WRITE;
        ST_DONE: begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
        ST_ERROR: state_d = ST_ERROR;
        default:  state_d = ST_IDLE;
      endcase
    end
    cyc_d = (state_d == ST_WRITE);
  end

  // State and output registers.
  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      state_q     <= ST_IDLE;
      en_prev_q   <= 1'b1;
      adr_q       <= {AW{1'b0}};
      dat_q       <= {DW{1'b0}};
      sel_q       <= 4'h0;
      count_q     <= {CW{1'b0}};
      words_q     <= {CW{1'b0}};
      bus_error_q <= 1'b0;
      have_q      <= 1'b0;
      cyc_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      en_prev_q   <= en_prev_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      count_q     <= count_d;
      words_q     <= words_d;
      bus_error_q <= bus_error_d;
      have_q      <= have_d;
      cyc_q       <= cyc_d;
      done_q      <= done_d;
    end
  end

  // Dropping enable kills the bus cycle in the same clock.
  assign wb_master_cyc_o = cyc_q & enable;
  assign wb_master_stb_o = cyc_q & enable;
  assign wb_master_we_o  = cyc_q & enable;
  assign wb_master_adr_o = adr_q;
  assign wb_master_dat_o = dat_q;
  assign wb_master_sel_o = sel_q;
  assign wb_master_cti_o = CTI_CLASSIC;
  assign wb_master_bte_o = BTE_LINEAR;
  assign done            = done_q;
  assign bus_error       = bus_error_q;
  assign words_written   = words_q;

endmodule

// File: tb/tb_wb_daq_sample_writer.sv
// Scoreboard bench: expected RAM writes are queued with the stimulus and
// popped when the Wishbone slave model acknowledges a write.
module tb_wb_daq_sample_writer;

  logic        wb_clk = 1'b0;
  logic        wb_rst;
  logic        enable;
  logic [31:0] start_addr;
  logic [15:0] sample_count;
  logic        sample_valid;
  logic [31:0] sample_data;
  logic        sample_ready;
  logic [31:0] adr, dat, dat_i;
  logic [3:0]  sel;
  logic        we, cyc, stb, ack, err, rty;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        done_o, berr_o;
  logic [15:0] words;

  wb_daq_sample_writer #(.AW(32), .DW(32), .CW(16)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .enable(enable),
    .start_addr(start_addr), .sample_count(sample_count),
    .sample_valid(sample_valid), .sample_data(sample_data), .sample_ready(sample_ready),
    .wb_master_adr_o(adr), .wb_master_dat_o(dat), .wb_master_sel_o(sel),
    .wb_master_we_o(we), .wb_master_cyc_o(cyc), .wb_master_stb_o(stb),
    .wb_master_cti_o(cti), .wb_master_bte_o(bte),
    .wb_master_dat_i(dat_i), .wb_master_ack_i(ack), .wb_master_err_i(err),
    .wb_master_rty_i(rty), .done(done_o), .bus_error(berr_o), .words_written(words)
  );

  always #5 wb_clk = ~wb_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [31:0] src_q[$];
  logic [63:0] exp_q[$];
  logic [31:0] mem[logic [31:0]];
  int          ack_times[$];

  int beat_idx = 0, err_at = -1, rty_at = -1, stall_at = -1;
  bit multi = 0, rty_used = 0, pend_ack = 0, pend_rty = 0, took = 0;
  int ncyc = 0, cyc_cnt = 0, done_cnt = 0, gap_st = 0;
  int first_xfer = -1, first_stb = -1;
  logic [31:0] rty_adr;

  // Slave response model: err > ack > rty, optionally several at once.
  always_comb begin
    err = 1'b0; rty = 1'b0; ack = 1'b0;
    if (stb && beat_idx != stall_at) begin
      err = (beat_idx == err_at);
      rty = (beat_idx == rty_at) && !rty_used;
      ack = multi || (!err && !rty);
    end
  end

  // Bus monitor and scoreboard, sampled on the falling edge.
  always @(negedge wb_clk) begin
    logic [63:0] e;
    ncyc++;
    if (pend_ack) beat_idx++;
    if (pend_rty) rty_used = 1;
    pend_ack = 0; pend_rty = 0;
    took = sample_valid && sample_ready;
    if (took && first_xfer < 0) first_xfer = ncyc;
    if (cyc) cyc_cnt++;
    if (done_o) done_cnt++;
    if (gap_st == 1) begin
      chk("retry_idle", stb, 1'b0);
      gap_st = 2;
    end else if (gap_st == 2) begin
      chk("retry_stb", stb, 1'b1);
      chk("retry_adr", adr, rty_adr);
      gap_st = 0;
    end
    if (stb && beat_idx != stall_at) begin
      chk("bus_ctl", {cyc, we, sel, cti, bte}, {1'b1, 1'b1, 4'hF, 3'b000, 2'b00});
      if (first_stb < 0) first_stb = ncyc;
      if (err) begin
      end else if (ack) begin
        chk("sb_nonempty", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("wr_adr", adr, e[63:32]);
          chk("wr_dat", dat, e[31:0]);
        end
        mem[adr] = dat;
        pend_ack = 1;
        ack_times.push_back(ncyc);
      end else if (rty) begin
        pend_rty = 1;
        rty_adr  = adr;
        gap_st   = 1;
      end
    end
  end

  // Sample source: presents the head of src_q until it is taken.
  always @(posedge wb_clk) begin
    #2;
    if (took && src_q.size() != 0) void'(src_q.pop_front());
    took = 0;
    sample_valid = (src_q.size() != 0);
    sample_data  = (src_q.size() != 0) ? src_q[0] : 32'h0;
  end

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'hDEAD_DEAD;
  endfunction

  task automatic load(input logic [31:0] a, input int n, input logic [31:0] base, input int n_exp);
    for (int i = 0; i < n; i++) begin
      src_q.push_back(base + 32'(i));
      if (i < n_exp) exp_q.push_back({a + 32'(4 * i), base + 32'(i)});
    end
  endtask

  task automatic start_run(input logic [31:0] a, input logic [15:0] n);
    beat_idx = 0; rty_used = 0;
    start_addr = a; sample_count = n; enable = 1'b0;
    @(posedge wb_clk); #1;
    enable = 1'b1;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge wb_clk);
      seen = done_o;
    end
    chk(tag, seen, 1'b1);
    @(posedge wb_clk); #1;
  endtask

  task automatic wait_sig(input string tag, input int budget, input bit want_berr);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge wb_clk);
      seen = want_berr ? berr_o : (stb && beat_idx == stall_at);
    end
    chk(tag, seen, 1'b1);
    @(posedge wb_clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout got=0 exp=1");
    $fatal(1, "timeout");
  end

  initial begin
    int d0, c0;
    wb_rst = 1'b0; enable = 1'b0; start_addr = 32'h0; sample_count = 16'h0;
    sample_valid = 1'b0; sample_data = 32'h0; dat_i = 32'h0;
    repeat (3) @(posedge wb_clk); #1;
    chk("rst_cyc", cyc, 1'b0);     chk("rst_stb", stb, 1'b0);
    chk("rst_we", we, 1'b0);       chk("rst_ready", sample_ready, 1'b0);
    chk("rst_done", done_o, 1'b0); chk("rst_berr", berr_o, 1'b0);
    chk("rst_adr", adr, 32'h0);    chk("rst_dat", dat, 32'h0);
    chk("rst_words", words, 16'h0); chk("rst_sel", sel, 4'h0);
    chk("rst_cti", cti, 3'h0);     chk("rst_bte", bte, 2'h0);
    wb_rst = 1'b1;
    repeat (2) @(posedge wb_clk); #1;

    // Basic run with zero-wait acks
    load(32'h100, 4, 32'hA0, 4);
    d0 = done_cnt; ack_times.delete(); first_xfer = -1; first_stb = -1;
    start_run(32'h100, 16'd4);
    wait_done("t1_done", 60);
    repeat (3) @(posedge wb_clk); #1;
    chk("t1_words", words, 16'd4);
    chk("t1_done_cnt", done_cnt - d0, 1);
    for (int i = 0; i < 4; i++) chk("t1_mem", rd(32'h100 + 32'(4 * i)), 32'hA0 + 32'(i));
    chk("t1_rate", (ack_times.size() == 4) ? ack_times[3] - ack_times[0] : -1, 9);
    chk("t1_latency", (first_stb - first_xfer) >= 2, 1'b1);
    chk("t1_sb_empty", exp_q.size(), 0);

    // Zero count: done on the second cycle after the edge, no bus activity
    d0 = done_cnt; c0 = cyc_cnt;
    start_run(32'h0, 16'd0);
    @(negedge wb_clk); chk("t2_done_c0", done_o, 1'b0);
    @(negedge wb_clk); chk("t2_done_c1", done_o, 1'b0);
    @(negedge wb_clk); chk("t2_done_c2", done_o, 1'b1);
    repeat (3) @(posedge wb_clk); #1;
    chk("t2_done_cnt", done_cnt - d0, 1);
    chk("t2_no_cyc", cyc_cnt - c0, 0);

    // Retry on the second word
    rty_at = 1; d0 = done_cnt;
    load(32'h200, 4, 32'hB0, 4);
    start_run(32'h200, 16'd4);
    wait_done("t3_done", 80);
    chk("t3_words", words, 16'd4);
    chk("t3_mem", rd(32'h204), 32'hB1);
    chk("t3_rty_used", rty_used, 1'b1);
    chk("t3_sb_empty", exp_q.size(), 0);
    rty_at = -1;

    // Error on the third word
    err_at = 2; d0 = done_cnt;
    load(32'h300, 4, 32'hC0, 2);
    start_run(32'h300, 16'd4);
    wait_sig("t4_berr_seen", 60, 1'b1);
    repeat (4) @(posedge wb_clk); #1;
    chk("t4_berr", berr_o, 1'b1);
    chk("t4_words", words, 16'd2);
    chk("t4_no_done", done_cnt - d0, 0);
    chk("t4_idle_bus", {stb, sample_ready}, 2'b00);
    src_q.delete(); err_at = -1;
    start_run(32'h0, 16'd0);
    @(negedge wb_clk); @(negedge wb_clk);
    chk("t4_berr_clr", berr_o, 1'b0);
    repeat (4) @(posedge wb_clk); #1;

    // Address wrap at the top of the space
    load(32'hFFFF_FFFC, 2, 32'hE0, 2);
    start_run(32'hFFFF_FFFC, 16'd2);
    wait_done("t5_done", 40);
    chk("t5_mem_hi", rd(32'hFFFF_FFFC), 32'hE0);
    chk("t5_mem_lo", rd(32'h0), 32'hE1);
    chk("t5_words", words, 16'd2);

    // Priority: ack beats rty, err beats both
    multi = 1; rty_at = 0;
    load(32'h400, 1, 32'hD0, 1);
    start_run(32'h400, 16'd1);
    wait_done("t6_ack_wins", 30);
    chk("t6_words", words, 16'd1);
    err_at = 0;
    load(32'h410, 1, 32'hD8, 0);
    start_run(32'h410, 16'd1);
    wait_sig("t6_err_wins", 30, 1'b1);
    chk("t6_words_err", words, 16'd0);
    multi = 0; rty_at = -1; err_at = -1;

    // Abort by enable low while a write is stalled
    stall_at = 1; d0 = done_cnt;
    load(32'h500, 2, 32'hF0, 1);
    start_run(32'h500, 16'd2);
    wait_sig("t7_stall_seen", 40, 1'b0);
    enable = 1'b0; #1;
    chk("t7_abort_cyc", {cyc, stb}, 2'b00);
    repeat (2) @(posedge wb_clk); #1;
    chk("t7_words_kept", words, 16'd1);
    chk("t7_no_done", done_cnt - d0, 0);
    stall_at = -1; src_q.delete();

    // Reset in the middle of a write
    stall_at = 0;
    load(32'h600, 1, 32'h11, 0);
    start_run(32'h600, 16'd1);
    wait_sig("t8_stall_seen", 40, 1'b0);
    wb_rst = 1'b0; #1;
    chk("t8_cyc", {cyc, stb, we}, 3'b000);
    chk("t8_adr", adr, 32'h0);
    chk("t8_dat", dat, 32'h0);
    chk("t8_words", words, 16'h0);
    chk("t8_sel", sel, 4'h0);
    @(posedge wb_clk); #1;
    wb_rst = 1'b1; stall_at = -1; src_q.delete();
    load(32'h700, 1, 32'h22, 0);
    c0 = cyc_cnt;
    repeat (10) @(posedge wb_clk); #1;
    chk("t8_quiet", cyc_cnt - c0, 0);
    chk("t8_no_take", src_q.size(), 1);
    chk("final_sb_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
